// File: rtl/tcdm_bank_responder.sv
// tcdm_bank_responder
// Responder side of the PE load/store interface. Each PE request is routed to
// one of NB_BANK word-interleaved single-port SRAM banks. Each bank has its own
// round-robin arbiter. Grants are returned in the request cycle, and load data
// is returned one cycle later.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   load_store_req_i         per-PE request valid
//   load_store_data_req_i    per-PE request type (1 = load, 0 = store)
//   dmem_addr_i              per-PE byte address
//   dmem_din_i, dmem_we_i    per-PE store data and byte strobes
//   load_store_grant_o       per-PE grant (combinational, same cycle)
//   data_req_valid_o         per-PE load response valid (one cycle after grant)
//   dmem_dout_o              per-PE load data (zero when not valid)
//   bank_en_o, bank_we_o     per-bank access enable and byte write strobes
//   bank_addr_o              per-bank word address
//   bank_wdata_o             per-bank write data
//   bank_rdata_i             per-bank read data (one cycle after bank_en_o)
//   dbg_conflict_o           per-PE saturating count of stalled request cycles
module tcdm_bank_responder #(
  parameter int unsigned N_REQ      = 16,
  parameter int unsigned NB_BANK    = 16,
  parameter int unsigned BANK_AW    = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    load_store_req_i,
  input  logic [N_REQ-1:0]                    load_store_data_req_i,
  input  logic [N_REQ-1:0][31:0]              dmem_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    dmem_din_i,
  input  logic [N_REQ-1:0][3:0]               dmem_we_i,
  output logic [N_REQ-1:0]                    load_store_grant_o,
  output logic [N_REQ-1:0]                    data_req_valid_o,
  output logic [N_REQ-1:0][DATA_WIDTH-1:0]    dmem_dout_o,
  output logic [NB_BANK-1:0]                  bank_en_o,
  output logic [NB_BANK-1:0][3:0]             bank_we_o,
  output logic [NB_BANK-1:0][BANK_AW-1:0]     bank_addr_o,
  output logic [NB_BANK-1:0][DATA_WIDTH-1:0]  bank_wdata_o,
  input  logic [NB_BANK-1:0][DATA_WIDTH-1:0]  bank_rdata_i,
  output logic [N_REQ-1:0][31:0]              dbg_conflict_o
);

  localparam int unsigned BW = $clog2(NB_BANK);
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0][BW-1:0]      pe_bank_s;
  logic [N_REQ-1:0][BANK_AW-1:0] pe_row_s;
  logic [N_REQ-1:0]              gnt_s;
  logic [NB_BANK-1:0]            bank_gnt_s;
  logic [NB_BANK-1:0][PW-1:0]    winner_s;
  logic [NB_BANK-1:0][PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]              valid_q, valid_d;
  logic [N_REQ-1:0][BW-1:0]      bank_q;
  logic [N_REQ-1:0][31:0]        cnt_q, cnt_d;
  logic                          unused_addr_s;

  // Byte-offset bits and bits above the row field are ignored, so addresses wrap.
  assign unused_addr_s = ^dmem_addr_i;

  // Address decode: word-interleaved bank select, then the row within the bank.
  always_comb begin
    pe_bank_s = '0;
    pe_row_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pe_bank_s[i] = dmem_addr_i[i][2 +: BW];
      pe_row_s[i]  = dmem_addr_i[i][2 + BW +: BANK_AW];
    end
  end

  // Per-bank round-robin arbitration, bank drive, and pointer next state.
  always_comb begin
    logic [PW-1:0] cand;
    cand         = '0;
    gnt_s        = '0;
    bank_gnt_s   = '0;
    winner_s     = '0;
    ptr_d        = ptr_q;
    bank_en_o    = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      // The search starts at ptr_q[b]. The first matching requester wins.
      for (int k = 0; k < N_REQ; k++) begin
        cand = PW'((32'(ptr_q[b]) + 32'(k)) % N_REQ);
        if (!rst && !bank_gnt_s[b] && load_store_req_i[cand] &&
            (pe_bank_s[cand] == BW'(b))) begin
          bank_gnt_s[b] = 1'b1;
          winner_s[b]   = cand;
        end else begin
          bank_gnt_s[b] = bank_gnt_s[b];
        end
      end
      if (bank_gnt_s[b]) begin
        gnt_s[winner_s[b]] = 1'b1;
        bank_en_o[b]       = 1'b1;
        bank_addr_o[b]     = pe_row_s[winner_s[b]];
        bank_wdata_o[b]    = dmem_din_i[winner_s[b]];
        bank_we_o[b]       = load_store_data_req_i[winner_s[b]] ? 4'b0000
                                                                : dmem_we_i[winner_s[b]];
        ptr_d[b]           = (winner_s[b] == PW'(N_REQ - 1)) ? PW'(0)
                                                             : winner_s[b] + PW'(1);
      end else begin
        ptr_d[b] = ptr_q[b];
      end
    end
  end

  // Response valid next state and saturating stall counters.
  always_comb begin
    valid_d = gnt_s & load_store_data_req_i;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (load_store_req_i[i] && !gnt_s[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers: arbiter pointers, pending responses, and conflict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= '0;
      bank_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      bank_q  <= pe_bank_s;
      cnt_q   <= cnt_d;
    end
  end

  // Response path: the data is only available in the return cycle, so it is
  // muxed combinationally. rst masks a response that is still in flight.
  always_comb begin
    data_req_valid_o = valid_q & ~{N_REQ{rst}};
    dmem_dout_o      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (data_req_valid_o[i]) begin
        dmem_dout_o[i] = bank_rdata_i[bank_q[i]];
      end else begin
        dmem_dout_o[i] = '0;
      end
    end
  end

  assign load_store_grant_o = gnt_s;
  assign dbg_conflict_o     = cnt_q;

endmodule
